// File: rtl/simple_axi_to_axi_read.sv
// AXI4 read master: turns a (byte address, byte length) request into INCR bursts
// of at most 256 beats that never cross a 4 KB boundary, one AR outstanding.
module simple_axi_to_axi_read #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int LEN_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_rvalid,
    input  logic [AXI_ADDR_W-1:0] m_raddr,
    input  logic [LEN_W-1:0]      m_rlen,
    output logic [AXI_DATA_W-1:0] m_rdata,
    output logic                  m_rdata_valid,
    input  logic                  m_rdata_ready,
    output logic                  m_rlast,
    output logic                  m_rdone,
    output logic                  m_rerror,
    output logic [AXI_ID_W-1:0]   m_axi_arid,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [AXI_ID_W-1:0]   m_axi_rid,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int BYTES = AXI_DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int CW    = (LEN_W > 12) ? LEN_W + 1 : 14;

    typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DONE} state_e;
    state_e state_q, state_d;

    logic [AXI_ADDR_W-1:0] addr_q, addr_d, araddr_q, araddr_d;
    logic [LEN_W-1:0]      remain_q, remain_d, total_beats, remain_after;
    logic [7:0]            arlen_q, arlen_d, beat_q, beat_d, burst_len;
    logic                  arvalid_q, arvalid_d, rerror_q, rerror_d;
    logic [LEN_W:0]        len_round;
    logic [12:0]           to4k_bytes;
    logic [CW-1:0]         to4k_beats, burst_n;
    logic [8:0]            burst_beats;
    logic                  beat_hs, burst_end, in_data, rid_unused;

    assign len_round    = {1'b0, m_rlen} + (LEN_W+1)'(BYTES - 1);
    assign total_beats  = LEN_W'(len_round >> SZ);
    assign burst_beats  = {1'b0, arlen_q} + 9'd1;
    assign remain_after = remain_q - LEN_W'(burst_beats);
    assign burst_end    = (beat_q == arlen_q);
    assign beat_hs      = (state_q == DATA) && m_axi_rvalid && m_rdata_ready;
    assign rid_unused   = ^m_axi_rid;

    // Next burst = min(remaining, 256, beats left before the 4 KB line).
    always_comb begin
        to4k_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
        to4k_beats = CW'(to4k_bytes >> SZ);
        burst_n    = CW'(remain_q);
        if (burst_n > CW'(256)) burst_n = CW'(256);
        if (burst_n > to4k_beats) burst_n = to4k_beats;
        burst_len  = 8'(burst_n - CW'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (m_rvalid) state_d = (total_beats == '0) ? DONE : CALC;
            CALC: state_d = ADDR;
            ADDR: if (m_axi_arready) state_d = DATA;
            DATA: if (beat_hs && burst_end) state_d = (remain_after == '0) ? DONE : CALC;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_data       = rst && (state_q == DATA);
        m_rdata_valid = in_data && m_axi_rvalid;
        m_axi_rready  = in_data && m_rdata_ready;
        m_rlast       = m_rdata_valid && burst_end && (remain_q == LEN_W'(burst_beats));
        m_rdone       = (state_q == DONE);
    end

    always_comb begin
        addr_d    = addr_q;
        remain_d  = remain_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        beat_d    = beat_q;
        rerror_d  = rerror_q;
        case (state_q)
            IDLE: if (m_rvalid) begin
                addr_d   = m_raddr & ~AXI_ADDR_W'(BYTES - 1);
                remain_d = total_beats;
                rerror_d = 1'b0;
                beat_d   = '0;
            end
            CALC: begin
                araddr_d  = addr_q;
                arlen_d   = burst_len;
                arvalid_d = 1'b1;
                beat_d    = '0;
            end
            ADDR: if (m_axi_arready) arvalid_d = 1'b0;
            DATA: if (beat_hs) begin
                // Progress is tracked by the local counter; a bad rlast only flags an error.
                if (m_axi_rresp != 2'b00 || m_axi_rlast != burst_end) rerror_d = 1'b1;
                if (burst_end) begin
                    beat_d   = '0;
                    addr_d   = addr_q + (AXI_ADDR_W'(burst_beats) << SZ);
                    remain_d = remain_after;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            remain_q  <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            rerror_q  <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
            beat_q    <= beat_d;
            rerror_q  <= rerror_d;
        end
    end

    assign m_rdata       = m_axi_rdata;
    assign m_rerror      = rerror_q;
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'h2;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arqos   = 4'h0;
    assign m_axi_arvalid = arvalid_q;

endmodule

// File: tb/tb_simple_axi_to_axi_read.sv
// Bench for simple_axi_to_axi_read: AXI slave + consumer stimulus, burst-plan
// model with a per-cycle compare process, and literal AR/beat expectations.
module tb_simple_axi_to_axi_read;
    localparam int AW = 32, DW = 32, IW = 4, LW = 20, B = 4;

    logic          clk, rst;
    logic          m_rvalid, m_rdata_valid, m_rdata_ready, m_rlast, m_rdone, m_rerror;
    logic [AW-1:0] m_raddr, m_axi_araddr;
    logic [LW-1:0] m_rlen;
    logic [DW-1:0] m_rdata, m_axi_rdata;
    logic [IW-1:0] m_axi_arid, m_axi_rid;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize, m_axi_arprot;
    logic [1:0]    m_axi_arburst, m_axi_rresp;
    logic [3:0]    m_axi_arcache, m_axi_arqos;
    logic          m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

    simple_axi_to_axi_read #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .m_rvalid(m_rvalid), .m_raddr(m_raddr), .m_rlen(m_rlen),
        .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready),
        .m_rlast(m_rlast), .m_rdone(m_rdone), .m_rerror(m_rerror),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; int l; } ar_t;
    ar_t exp_q[$];
    ar_t obs_q[$];
    int total = 0, bad = 0;
    int exp_total = 0;
    logic [31:0] a0 = '0;
    bit stall_en = 0;
    int err_beat = -1, bad_last_beat = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    // Burst plan straight from the splitting rules.
    function automatic void plan(input logic [31:0] addr, input int len);
        int beats, room, n;
        logic [31:0] a;
        exp_q.delete();
        a = addr & ~32'(B - 1);
        a0 = a;
        beats = (len + B - 1) / B;
        exp_total = beats;
        while (beats > 0) begin
            room = (4096 - int'(a % 32'd4096)) / B;
            n = beats;
            if (n > 256) n = 256;
            if (n > room) n = room;
            exp_q.push_back(ar_t'{a, n - 1});
            a += 32'(n * B);
            beats -= n;
        end
    endfunction

    // AXI slave and consumer
    int s_rem = 0, s_gidx = 0;
    logic [31:0] s_addr = '0;
    initial begin : slave
        bit arf, rf;
        logic [31:0] aa;
        logic [7:0] al;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0;
        m_axi_rlast = 0; m_axi_rid = '0; m_rdata_ready = 0;
        forever begin
            @(negedge clk);
            arf = m_axi_arvalid && m_axi_arready;
            rf  = m_axi_rvalid && m_axi_rready;
            aa  = m_axi_araddr;
            al  = m_axi_arlen;
            @(posedge clk);
            #1;
            if (!rst) begin
                s_rem = 0; s_gidx = 0; m_axi_arready = 0; m_axi_rvalid = 0;
                m_axi_rlast = 0; m_axi_rresp = 0; m_rdata_ready = 0;
                continue;
            end
            if (rf) begin s_rem--; s_addr += B; s_gidx++; end
            if (arf) begin s_rem = int'(al) + 1; s_addr = aa; end
            if (!m_rvalid && s_rem == 0) s_gidx = 0;
            m_axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            m_rdata_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_axi_rid = 4'($urandom_range(0, 15));
            if (!(m_axi_rvalid && !rf)) begin
                if (s_rem > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = pat(s_addr);
                    m_axi_rresp  = (s_gidx == err_beat) ? 2'b10 : 2'b00;
                    m_axi_rlast  = (s_rem == 1) ^ (s_gidx == bad_last_beat);
                end else begin
                    m_axi_rvalid = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model
    int k = 0, bib = 0, cur_len = 0, ar_idx = 0;
    logic exp_done = 0, exp_err = 0, prev_mrv = 0, prev_arv = 0, prev_arfire = 0;
    logic [31:0] prev_araddr = '0;
    logic [7:0] prev_arlen = '0;
    always @(negedge clk) begin : compare
        logic dn, ne, lob;
        ar_t e;
        if (!rst) begin
            check("rst_arvalid", m_axi_arvalid, 0);
            check("rst_rready", m_axi_rready, 0);
            check("rst_rdata_valid", m_rdata_valid, 0);
            check("rst_rlast", m_rlast, 0);
            check("rst_rdone", m_rdone, 0);
            check("rst_rerror", m_rerror, 0);
            k = 0; bib = 0; cur_len = 0; ar_idx = 0;
            exp_done = 0; exp_err = 0; prev_mrv = 0; prev_arv = 0; prev_arfire = 0;
        end else begin
            check("rdone", m_rdone, exp_done);
            check("rerror", m_rerror, exp_err);
            dn = 0;
            ne = exp_err;
            if (m_rvalid && !prev_mrv) begin
                ne = 0; k = 0; bib = 0; cur_len = 0; ar_idx = 0;
                obs_q.delete();
                if (exp_total == 0) dn = 1;
            end
            if (m_axi_arvalid) begin
                check("ar_one_outstanding", cur_len != 0, 0);
                if (prev_arv && !prev_arfire)
                    check("ar_stable", {m_axi_araddr, m_axi_arlen}, {prev_araddr, prev_arlen});
                if (m_axi_arready) begin
                    check("ar_expected", ar_idx < exp_q.size(), 1);
                    if (ar_idx < exp_q.size()) begin
                        e = exp_q[ar_idx];
                        check("ar_addr_len", {m_axi_araddr, m_axi_arlen}, {e.a, 8'(e.l)});
                    end
                    check("ar_const",
                          {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos},
                          {4'h0, 3'd2, 2'b01, 1'b0, 4'h2, 3'b010, 4'h0});
                    obs_q.push_back(ar_t'{m_axi_araddr, int'(m_axi_arlen)});
                    ar_idx++;
                    cur_len = int'(m_axi_arlen) + 1;
                    bib = 0;
                end
            end
            prev_arv    = m_axi_arvalid;
            prev_arfire = m_axi_arvalid && m_axi_arready;
            prev_araddr = m_axi_araddr;
            prev_arlen  = m_axi_arlen;
            check("rdata_valid", m_rdata_valid, m_axi_rvalid);
            if (m_axi_rvalid) begin
                check("rready_mirror", m_axi_rready, m_rdata_ready);
                check("rdata_pass", m_rdata, m_axi_rdata);
                check("rlast", m_rlast, k == exp_total - 1);
            end else begin
                check("rlast_idle", m_rlast, 0);
            end
            if (m_axi_rvalid && m_axi_rready) begin
                check("beat_data", m_rdata, pat(a0 + 32'(k * B)));
                lob = (bib == cur_len - 1);
                if (m_axi_rresp != 2'b00 || m_axi_rlast != lob) ne = 1;
                bib++;
                k++;
                if (k == exp_total) dn = 1;
                if (bib == cur_len) cur_len = 0;
            end
            prev_mrv = m_rvalid;
            exp_done = dn;
            exp_err  = ne;
        end
    end

    task automatic run_req(input logic [31:0] addr, input int len, input bit stall, input int eb, input int lb);
        int cyc;
        plan(addr, len);
        stall_en = stall;
        err_beat = eb;
        bad_last_beat = lb;
        @(posedge clk);
        #1;
        m_raddr = addr;
        m_rlen = 20'(len);
        m_rvalid = 1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!m_rdone && cyc < 5000);
        m_rvalid = 0;
        check("done_in_time", cyc < 5000, 1);
        check("all_ar_issued", ar_idx, exp_q.size());
        check("all_beats", k, exp_total);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_ar(input int i, input logic [31:0] a, input int l);
        check("ar_seen", obs_q.size() > i, 1);
        if (obs_q.size() > i) check("ar_literal", {obs_q[i].a, 8'(obs_q[i].l)}, {a, 8'(l)});
    endtask

    initial begin : main
        int cyc;
        m_rvalid = 0; m_raddr = '0; m_rlen = '0;
        rst = 1;
        #2 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_arvalid", m_axi_arvalid, 0);
        check("reset_rdone", m_rdone, 0);
        check("reset_rerror", m_rerror, 0);
        check("reset_rdata_valid", m_rdata_valid, 0);
        @(posedge clk);
        #2 rst = 1;
        repeat (2) @(posedge clk);

        run_req(32'h1000, 16, 0, -1, -1);
        check("ar_count_1000", obs_q.size(), 1);
        check_ar(0, 32'h1000, 3);
        check("beats_1000", k, 4);

        run_req(32'h0FF8, 32, 0, -1, -1);
        check("ar_count_ff8", obs_q.size(), 2);
        check_ar(0, 32'h0FF8, 1);
        check_ar(1, 32'h1000, 5);
        check("beats_ff8", k, 8);

        run_req(32'h0, 2000, 0, -1, -1);
        check("ar_count_2000", obs_q.size(), 2);
        check_ar(0, 32'h0, 255);
        check_ar(1, 32'h400, 243);
        check("beats_2000", k, 500);

        run_req(32'h20, 0, 0, -1, -1);
        check("ar_count_len0", obs_q.size(), 0);

        run_req(32'h40, 6, 0, -1, -1);
        check("ar_count_len6", obs_q.size(), 1);
        check_ar(0, 32'h40, 1);

        run_req(32'h1003, 9, 0, -1, -1);
        check_ar(0, 32'h1000, 2);

        run_req(32'h2000, 40, 1, 1, -1);
        check("err_slverr", m_rerror, 1);
        check("beats_stall", k, 10);

        run_req(32'h3FF0, 48, 1, -1, 2);
        check("err_rlast", m_rerror, 1);
        check_ar(0, 32'h3FF0, 3);
        check_ar(1, 32'h4000, 7);

        run_req(32'h500, 8, 0, -1, -1);
        check("err_cleared", m_rerror, 0);

        // Reset in the middle of a data burst
        plan(32'h4000, 64);
        stall_en = 0; err_beat = -1; bad_last_beat = -1;
        @(posedge clk);
        #1;
        m_raddr = 32'h4000; m_rlen = 20'd64; m_rvalid = 1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (k < 3 && cyc < 200);
        check("reached_data", k >= 3, 1);
        #1 rst = 0;
        #1;
        check("midrst_arvalid", m_axi_arvalid, 0);
        check("midrst_rready", m_axi_rready, 0);
        check("midrst_rdata_valid", m_rdata_valid, 0);
        check("midrst_rlast", m_rlast, 0);
        m_rvalid = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_rdone", m_rdone, 0);
        check("post_rst_rerror", m_rerror, 0);
        run_req(32'h100, 8, 0, -1, -1);
        check_ar(0, 32'h100, 1);
        check("beats_post_rst", k, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
